// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, init ROM, digit-frame builder and the phase/mode types
// used by the stopwatch display driver.
package max7219_pkg;

  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int unsigned NUM_INIT   = 5;
  localparam int unsigned NUM_DIGITS = 6;

  typedef enum logic [1:0] {LOAD, SHIFT, GAP, IDLE} phase_e;
  typedef enum logic {MODE_INIT, MODE_REFRESH} mode_e;

  typedef struct packed {
    logic [2:0] min_x0;
    logic [3:0] min_0x;
    logic [2:0] sec_x0;
    logic [3:0] sec_0x;
    logic [3:0] ces_x0;
    logic [3:0] ces_0x;
  } digits_t;

  function automatic logic [15:0] init_frame(input logic [2:0] idx, input logic [3:0] intensity);
    logic [15:0] f;
    case (idx)
      3'd0:    f = {4'h0, ADDR_TEST,      8'h00};
      3'd1:    f = {4'h0, ADDR_SCANLIMIT, 8'h05};
      3'd2:    f = {4'h0, ADDR_DECODE,    8'h3F};
      3'd3:    f = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
      default: f = {4'h0, ADDR_SHUTDOWN,  8'h01};
    endcase
    return f;
  endfunction

  // Decimal points after the seconds and minutes ones digits give MM.SS.CC.
  function automatic logic [15:0] digit_frame(input logic [2:0] idx, input digits_t d);
    logic [3:0] bcd;
    logic       dp;
    logic [3:0] addr;
    dp = 1'b0;
    case (idx)
      3'd0:    bcd = d.ces_0x;
      3'd1:    bcd = d.ces_x0;
      3'd2:    begin bcd = d.sec_0x; dp = 1'b1; end
      3'd3:    bcd = {1'b0, d.sec_x0};
      3'd4:    begin bcd = d.min_0x; dp = 1'b1; end
      default: bcd = {1'b0, d.min_x0};
    endcase
    addr = ADDR_DIGIT0 + {1'b0, idx};
    return {4'h0, addr, dp, 3'b000, bcd};
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Serialises one 16-bit MAX7219 frame: LOAD cycle, 16 sck bits MSB first, then a cs_n-high gap.
// done is high in IDLE and in the last gap cycle, when a back-to-back start is accepted.
module spi_frame_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        start,
  input  logic [15:0] frame,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  output logic        done
);

  localparam int unsigned     CW       = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_HIGH = CW'(CLK_DIV);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          bit_end;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bit_end = (cnt_q == CNT_LAST);
    done    = (phase_q == IDLE) || ((phase_q == GAP) && bit_end);

    unique case (phase_q)
      LOAD: begin
        phase_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          sh_d = {sh_q[14:0], 1'b0};
          if (bit_q == 4'd15) phase_d = GAP;
          else                bit_d   = bit_q + 4'd1;
        end
      end
      GAP:     cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      default: ;
    endcase

    if (done) begin
      phase_d = start ? LOAD : IDLE;
      if (start) begin
        sh_d  = frame;
        bit_d = '0;
        cnt_d = '0;
      end
    end

    // Outputs are computed from next state so they leave flops aligned with the phase.
    cs_n_d = !((phase_d == LOAD) || (phase_d == SHIFT));
    sck_d  = (phase_d == SHIFT) && (cnt_d >= CNT_HIGH);
    mosi_d = cs_n_d ? 1'b0 : sh_d[15];
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign cs_n = cs_n_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/max7219_display_driver.sv
// Stopwatch digit bus to MAX7219: sends the init sequence after reset, then refreshes
// digits 1..6 continuously from a snapshot taken at the start of each pass.
module max7219_display_driver
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       ena,
  input  logic [3:0] ces_0X,
  input  logic [3:0] ces_X0,
  input  logic [3:0] sec_0X,
  input  logic [2:0] sec_X0,
  input  logic [3:0] min_0X,
  input  logic [2:0] min_X0,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  output logic       init_done
);

  mode_e       mode_q, mode_d;
  logic [2:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        init_done_q, init_done_d;
  digits_t     snap_q, snap_d;
  digits_t     live;
  digits_t     src;
  logic        start;
  logic        tx_done;
  logic [15:0] frame;

  always_comb begin
    live = '{min_x0: min_X0, min_0x: min_0X, sec_x0: sec_X0,
             sec_0x: sec_0X, ces_x0: ces_X0, ces_0x: ces_0X};
    mode_d      = mode_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    snap_d      = snap_q;

    if (busy_q && tx_done) begin
      if (mode_q == MODE_INIT) begin
        if (idx_q == 3'(NUM_INIT - 1)) begin
          mode_d      = MODE_REFRESH;
          idx_d       = '0;
          init_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? '0 : idx_q + 3'd1;
      end
    end

    // ena only gates new frames; the index still advances past the frame just finished.
    start  = ena && tx_done;
    busy_d = start ? 1'b1 : (tx_done ? 1'b0 : busy_q);

    if (start && (mode_d == MODE_REFRESH) && (idx_d == '0)) snap_d = live;
    src   = (idx_d == '0) ? live : snap_q;
    frame = (mode_d == MODE_INIT) ? init_frame(idx_d, INTENSITY) : digit_frame(idx_d, src);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      mode_q      <= MODE_INIT;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      snap_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      snap_q      <= snap_d;
    end
  end

  spi_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .res_n (res_n),
    .start (start),
    .frame (frame),
    .cs_n  (cs_n),
    .sck   (sck),
    .mosi  (mosi),
    .done  (tx_done)
  );

  assign init_done = init_done_q;

endmodule

// File: tb/tb_max7219_display_driver.sv
// Self-checking bench: decodes SPI frames from two driver instances (CLK_DIV=2 and 1)
// and compares them with tabulated and modelled MAX7219 frames.
module tb_max7219_display_driver;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] ces_0X = 4'd0, ces_X0 = 4'd0, sec_0X = 4'd0, min_0X = 4'd0;
  logic [2:0] sec_X0 = 3'd0, min_X0 = 3'd0;
  logic       cs_n0, sck0, mosi0, idn0;
  logic       cs_n1, sck1, mosi1, idn1;

  always #5 clk = ~clk;

  max7219_display_driver #(.CLK_DIV(2), .INTENSITY(4'h8)) dut0 (
    .clk(clk), .res_n(res_n), .ena(ena),
    .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
    .min_0X(min_0X), .min_X0(min_X0),
    .cs_n(cs_n0), .sck(sck0), .mosi(mosi0), .init_done(idn0)
  );

  max7219_display_driver #(.CLK_DIV(1), .INTENSITY(4'hF)) dut1 (
    .clk(clk), .res_n(res_n), .ena(ena),
    .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
    .min_0X(min_0X), .min_X0(min_X0),
    .cs_n(cs_n1), .sck(sck1), .mosi(mosi1), .init_done(idn1)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoders: shift mosi on sck rising edges while cs_n is low, emit on cs_n rising.
  logic [15:0] fq0[$];
  int unsigned tq0[$];
  int          rd0 = 0;
  logic [15:0] sh0 = '0;
  int          nb0 = 0;
  logic        pcs0 = 1'b1, psck0 = 1'b0, pmosi0 = 1'b0;
  int unsigned tl0 = 0, tid0 = 0;
  bit          seen0 = 1'b0;
  int          perr0 = 0;

  always @(negedge clk) begin
    if (!res_n) begin
      nb0 = 0; pcs0 = 1'b1; psck0 = 1'b0; pmosi0 = 1'b0; seen0 = 1'b0;
    end else begin
      if (pcs0 && !cs_n0) begin nb0 = 0; tl0 = cyc; end
      if (!cs_n0 && sck0 && !psck0) begin sh0 = {sh0[14:0], mosi0}; nb0++; end
      if (!pcs0 && cs_n0) begin
        fq0.push_back(sh0); tq0.push_back(tl0);
        if (nb0 != 16) perr0++;
      end
      if ((cs_n0 && sck0) || (sck0 && (mosi0 != pmosi0))) perr0++;
      if (idn0 && !seen0) begin seen0 = 1'b1; tid0 = cyc; end
      pcs0 = cs_n0; psck0 = sck0; pmosi0 = mosi0;
    end
  end

  logic [15:0] fq1[$];
  int unsigned tq1[$];
  int          rd1 = 0;
  logic [15:0] sh1 = '0;
  int          nb1 = 0;
  logic        pcs1 = 1'b1, psck1 = 1'b0, pmosi1 = 1'b0;
  int unsigned tl1 = 0, tid1 = 0;
  bit          seen1 = 1'b0;
  int          perr1 = 0;

  always @(negedge clk) begin
    if (!res_n) begin
      nb1 = 0; pcs1 = 1'b1; psck1 = 1'b0; pmosi1 = 1'b0; seen1 = 1'b0;
    end else begin
      if (pcs1 && !cs_n1) begin nb1 = 0; tl1 = cyc; end
      if (!cs_n1 && sck1 && !psck1) begin sh1 = {sh1[14:0], mosi1}; nb1++; end
      if (!pcs1 && cs_n1) begin
        fq1.push_back(sh1); tq1.push_back(tl1);
        if (nb1 != 16) perr1++;
      end
      if ((cs_n1 && sck1) || (sck1 && (mosi1 != pmosi1))) perr1++;
      if (idn1 && !seen1) begin seen1 = 1'b1; tid1 = cyc; end
      pcs1 = cs_n1; psck1 = sck1; pmosi1 = mosi1;
    end
  end

  typedef struct packed {
    logic [3:0]        c0, c1, s0;
    logic [2:0]        s1;
    logic [3:0]        m0;
    logic [2:0]        m1;
    logic [0:5][15:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] s0,
                              input logic [2:0] s1, input logic [3:0] m0, input logic [2:0] m1,
                              input logic [0:5][15:0] exp);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.s0 = s0; v.s1 = s1; v.m0 = m0; v.m1 = m1; v.exp = exp;
    return v;
  endfunction

  // Reference: register address = digit position + 1, dp on seconds/minutes ones digit.
  function automatic logic [15:0] model_frame(input int addr);
    int vals[6];
    int dp;
    vals[0] = int'(ces_0X); vals[1] = int'(ces_X0); vals[2] = int'(sec_0X);
    vals[3] = int'(sec_X0); vals[4] = int'(min_0X); vals[5] = int'(min_X0);
    dp = ((addr == 3) || (addr == 5)) ? 128 : 0;
    return 16'(addr * 256 + dp + vals[addr - 1]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=frame", nm);
  endtask

  task automatic next_frame0(output logic [15:0] fr, output int unsigned t, output bit ok);
    ok = 1'b0; fr = '0; t = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rd0 < fq0.size()) begin
        fr = fq0[rd0]; t = tq0[rd0]; rd0++; ok = 1'b1;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic wait_addr0(input logic [3:0] addr, output logic [15:0] fr, output bit ok);
    int unsigned t;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      next_frame0(fr, t, ok);
      if (!ok) return;
      if (fr[11:8] == addr) return;
    end
    ok = 1'b0;
  endtask

  // Collects the first full pass whose addr-1 LOAD came after the input change at tchg.
  task automatic get_pass(input int unsigned tchg, output logic [15:0] f[6], output bit ok);
    logic [15:0] fr;
    int unsigned t;
    int n;
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      next_frame0(fr, t, ok);
      if (!ok) return;
      if (n == 0) begin
        if (fr[11:8] == 4'h1 && t > tchg) begin f[0] = fr; n = 1; end
      end else begin
        f[n] = fr; n++;
      end
    end
    ok = (n == 6);
  endtask

  task automatic apply(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] s0,
                       input logic [2:0] s1, input logic [3:0] m0, input logic [2:0] m1,
                       output int unsigned tchg);
    @(negedge clk);
    ces_0X = c0; ces_X0 = c1; sec_0X = s0; sec_X0 = s1; min_0X = m0; min_X0 = m1;
    tchg = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t        tbl[4];
    logic [15:0] ini0[5];
    logic [15:0] ini1[5];
    logic [15:0] f[6];
    logic [15:0] fr;
    logic [15:0] texp[5];
    int unsigned tl[5];
    int unsigned t, tchg;
    bit          ok;
    int          bad;

    tbl[0] = mk(4'h6, 4'h5, 4'h4, 3'h3, 4'h2, 3'h1,
                {16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601});
    tbl[1] = mk(4'h0, 4'h0, 4'h0, 3'h0, 4'h0, 3'h0,
                {16'h0100, 16'h0200, 16'h0380, 16'h0400, 16'h0580, 16'h0600});
    tbl[2] = mk(4'h9, 4'h9, 4'h9, 3'h5, 4'h9, 3'h5,
                {16'h0109, 16'h0209, 16'h0389, 16'h0405, 16'h0589, 16'h0605});
    tbl[3] = mk(4'hF, 4'hA, 4'hC, 3'h7, 4'hE, 3'h6,
                {16'h010F, 16'h020A, 16'h038C, 16'h0407, 16'h058E, 16'h0606});
    ini0 = '{16'h0F00, 16'h0B05, 16'h093F, 16'h0A08, 16'h0C01};
    ini1 = '{16'h0F00, 16'h0B05, 16'h093F, 16'h0A0F, 16'h0C01};

    ces_0X = 4'h6; ces_X0 = 4'h5; sec_0X = 4'h4; sec_X0 = 3'h3; min_0X = 4'h2; min_X0 = 3'h1;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n0), 32'd1);
    chk("rst_sck", 32'(sck0), 32'd0);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_init_done", 32'(idn0), 32'd0);
    chk("rst_cs_n_div1", 32'(cs_n1), 32'd1);
    @(negedge clk);
    res_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      next_frame0(fr, t, ok);
      if (!ok) fail_timeout($sformatf("init_frame%0d", i));
      else chk($sformatf("init_frame%0d", i), 32'(fr), 32'(ini0[i]));
      tl[i] = t;
    end
    for (int i = 1; i < 5; i++) chk($sformatf("init_period%0d", i), tl[i] - tl[i-1], 32'd69);
    repeat (10) @(posedge clk);
    chk("init_done_time", tid0, tl[4] + 69);
    chk("init_done_level", 32'(idn0), 32'd1);

    if (fq1.size() < 5) fail_timeout("div1_init");
    else begin
      for (int i = 0; i < 5; i++) chk($sformatf("div1_init_frame%0d", i), 32'(fq1[i]), 32'(ini1[i]));
      for (int i = 1; i < 5; i++) chk($sformatf("div1_period%0d", i), tq1[i] - tq1[i-1], 32'd35);
      chk("div1_init_done_time", tid1, tq1[4] + 35);
    end

    for (int i = 0; i < 4; i++) begin
      apply(tbl[i].c0, tbl[i].c1, tbl[i].s0, tbl[i].s1, tbl[i].m0, tbl[i].m1, tchg);
      get_pass(tchg, f, ok);
      if (!ok) fail_timeout($sformatf("tbl%0d", i));
      else for (int j = 0; j < 6; j++)
        chk($sformatf("tbl%0d_addr%0d", i, j + 1), 32'(f[j]), 32'(tbl[i].exp[j]));
    end

    // Snapshot coherency: change digits during the addr-3 frame.
    apply(4'h6, 4'h5, 4'h4, 3'h3, 4'h2, 3'h1, tchg);
    get_pass(tchg, f, ok);
    if (!ok) fail_timeout("snap_base");
    else chk("snap_base_addr1", 32'(f[0]), 32'h0106);
    wait_addr0(4'h2, fr, ok);
    if (!ok) fail_timeout("snap_sync");
    repeat (10) @(posedge clk);
    @(negedge clk);
    ces_0X = 4'h7; min_0X = 4'h3;
    texp = '{16'h0384, 16'h0403, 16'h0582, 16'h0601, 16'h0107};
    for (int i = 0; i < 5; i++) begin
      next_frame0(fr, t, ok);
      if (!ok) fail_timeout($sformatf("snap_frame%0d", i));
      else chk($sformatf("snap_frame%0d", i), 32'(fr), 32'(texp[i]));
    end
    for (int i = 0; i < 4; i++) next_frame0(fr, t, ok);
    chk("snap_next_min", 32'(fr), 32'h0583);

    // ena dropped inside the addr-2 frame.
    wait_addr0(4'h1, fr, ok);
    if (!ok) fail_timeout("ena_sync");
    repeat (33) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    next_frame0(fr, t, ok);
    if (!ok) fail_timeout("ena_last_frame");
    else chk("ena_last_frame", 32'(fr), 32'h0205);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cs_n0 || sck0) bad++;
    end
    chk("ena_parked", 32'(bad), 32'd0);
    chk("ena_no_frames", 32'(fq0.size() - rd0), 32'd0);
    ena = 1'b1;
    next_frame0(fr, t, ok);
    if (!ok) fail_timeout("ena_resume");
    else chk("ena_resume", 32'(fr), 32'h0384);

    for (int r = 0; r < 6; r++) begin
      apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), tchg);
      get_pass(tchg, f, ok);
      if (!ok) fail_timeout($sformatf("rnd%0d", r));
      else for (int j = 0; j < 6; j++)
        chk($sformatf("rnd%0d_addr%0d", r, j + 1), 32'(f[j]), 32'(model_frame(j + 1)));
    end

    // Asynchronous reset during bit 7 of a refresh frame.
    wait_addr0(4'h1, fr, ok);
    if (!ok) fail_timeout("rst_sync");
    repeat (38) @(posedge clk);
    #1;
    res_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs_n0), 32'd1);
    chk("midrst_sck", 32'(sck0), 32'd0);
    chk("midrst_mosi", 32'(mosi0), 32'd0);
    chk("midrst_init_done", 32'(idn0), 32'd0);
    chk("midrst_init_done_div1", 32'(idn1), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd0 = fq0.size();
    rd1 = fq1.size();
    res_n = 1'b1;
    next_frame0(fr, t, ok);
    if (!ok) fail_timeout("restart_frame");
    else chk("restart_frame", 32'(fr), 32'h0F00);
    for (int i = 0; i < 2000 && fq1.size() <= rd1; i++) @(posedge clk);
    if (fq1.size() <= rd1) fail_timeout("restart_frame_div1");
    else chk("restart_frame_div1", 32'(fq1[rd1]), 32'h0F00);

    chk("protocol_div2", 32'(perr0), 32'd0);
    chk("protocol_div1", 32'(perr1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
